// File: rtl/coproc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coproc_pkg
//  Description : Shared types, status codes and PIO field layout for the
//                image coprocessor command path.
//  Revision    : 1.0 - initial release
// ============================================================================
package coproc_pkg;

  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_COPY     = 4'd1,
    OP_ZOOM_IN  = 4'd2,
    OP_ZOOM_OUT = 4'd3,
    OP_WINDOW   = 4'd4
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT      = 3'd3,
    ST_DONE_HOLD = 3'd4
  } state_e;

  localparam logic [2:0] c_STATUS_OK         = 3'd0;
  localparam logic [2:0] c_STATUS_ILLEGAL_OP = 3'd1;
  localparam logic [2:0] c_STATUS_BAD_WINDOW = 3'd2;
  localparam logic [2:0] c_STATUS_TIMEOUT    = 3'd3;

  // instruct word: [3:0] opcode, [5:4] scale; pos/dim words: [15:0] X/W, [31:16] Y/H
  localparam int c_OPC_LSB   = 0;
  localparam int c_OPC_W     = 4;
  localparam int c_SCALE_LSB = 4;
  localparam int c_SCALE_W   = 2;
  localparam int c_FIELD_W   = 16;
  localparam int c_LO_LSB    = 0;
  localparam int c_HI_LSB    = 16;

  localparam int c_IMG_W_DEF = 320;
  localparam int c_IMG_H_DEF = 240;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_WINDOW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_bounds_check.sv
`default_nettype none
// ============================================================================
//  Module      : window_bounds_check
//  Description : Combinational window-inside-image test; sums are one bit
//                wider than the fields so 16-bit wrap reads as out of bounds.
//  Revision    : 1.0 - initial release
// ============================================================================
module window_bounds_check
  import coproc_pkg::*;
#(
  parameter int IMG_W = c_IMG_W_DEF,
  parameter int IMG_H = c_IMG_H_DEF
) (
  input  logic [c_FIELD_W-1:0] i_x,
  input  logic [c_FIELD_W-1:0] i_y,
  input  logic [c_FIELD_W-1:0] i_w,
  input  logic [c_FIELD_W-1:0] i_h,
  output logic                 o_in_bounds
);

  localparam logic [c_FIELD_W:0] c_LIM_X = (c_FIELD_W + 1)'(IMG_W);
  localparam logic [c_FIELD_W:0] c_LIM_Y = (c_FIELD_W + 1)'(IMG_H);

  logic [c_FIELD_W:0] w_x_end;
  logic [c_FIELD_W:0] w_y_end;

  always_comb begin
    w_x_end     = {1'b0, i_x} + {1'b0, i_w};
    w_y_end     = {1'b0, i_y} + {1'b0, i_h};
    o_in_bounds = (i_w != '0) && (i_h != '0) &&
                  (w_x_end <= c_LIM_X) && (w_y_end <= c_LIM_Y);
  end

endmodule
`default_nettype wire

// File: rtl/coproc_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : coproc_cmd_sequencer
//  Description : Latches PIO commands, validates them, launches the
//                coprocessor and returns status through a pio_start/pio_done
//                four-phase handshake with a watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module coproc_cmd_sequencer
  import coproc_pkg::*;
#(
  parameter int IMG_W       = c_IMG_W_DEF,
  parameter int IMG_H       = c_IMG_H_DEF,
  parameter int TIMEOUT_CYC = 2 ** 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pio_reset,
  input  logic        pio_start,
  input  logic [31:0] pio_instruct,
  input  logic [31:0] pio_janela_pos,
  input  logic [31:0] pio_janela_dim,
  output logic        pio_done,
  output logic [2:0]  status,
  output logic        cp_start,
  output logic        cp_abort,
  output logic [3:0]  cp_opcode,
  output logic [1:0]  cp_scale,
  output logic [15:0] cp_x,
  output logic [15:0] cp_y,
  output logic [15:0] cp_w,
  output logic [15:0] cp_h,
  input  logic        cp_done,
  output logic        busy
);

  localparam int                c_WD_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // The counter is tested before its increment, so the limit is one below TIMEOUT_CYC-1
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 2);
  localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

  state_e              r_state;
  state_e              w_next_state;
  logic                r_start_q;
  logic [c_WD_W-1:0]   r_wdog;
  logic [3:0]          r_opcode;
  logic [1:0]          r_scale;
  logic [15:0]         r_x, r_y, r_w, r_h;
  logic                r_cp_start, r_cp_abort, r_pio_done, r_busy;
  logic [2:0]          r_status;

  logic                w_edge, w_latch, w_wd_clr, w_wd_inc, w_issue, w_abort;
  logic                w_status_ld, w_in_bounds;
  logic [2:0]          w_status_nxt;
  logic                w_unused_instr;

  assign w_edge         = pio_start & ~r_start_q;
  assign w_unused_instr = ^pio_instruct[31:c_SCALE_LSB + c_SCALE_W];

  window_bounds_check #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_bounds (
    .i_x         (r_x),
    .i_y         (r_y),
    .i_w         (r_w),
    .i_h         (r_h),
    .o_in_bounds (w_in_bounds)
  );

  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_wd_clr     = 1'b0;
    w_wd_inc     = 1'b0;
    w_issue      = 1'b0;
    w_abort      = 1'b0;
    w_status_ld  = 1'b0;
    w_status_nxt = c_STATUS_OK;

    if (pio_reset) begin
      w_next_state = ST_IDLE;
      w_status_ld  = 1'b1;
      w_abort      = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            w_latch      = 1'b1;
            w_wd_clr     = 1'b1;
            w_next_state = ST_CHECK;
          end
        end
        ST_CHECK: begin
          w_next_state = ST_DONE_HOLD;
          w_status_ld  = 1'b1;
          if (!is_legal_op(r_opcode)) begin
            w_status_nxt = c_STATUS_ILLEGAL_OP;
          end else if ((r_opcode == OP_WINDOW) && !w_in_bounds) begin
            w_status_nxt = c_STATUS_BAD_WINDOW;
          end else if (r_opcode == OP_NOP) begin
            w_status_nxt = c_STATUS_OK;
          end else begin
            w_status_ld  = 1'b0;
            w_issue      = 1'b1;
            w_next_state = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          w_next_state = ST_WAIT;
        end
        ST_WAIT: begin
          w_wd_inc = 1'b1;
          // completion takes priority over a coincident watchdog expiry
          if (cp_done) begin
            w_next_state = ST_DONE_HOLD;
            w_status_ld  = 1'b1;
            w_status_nxt = c_STATUS_OK;
          end else if (r_wdog == c_WD_LAST) begin
            w_next_state = ST_DONE_HOLD;
            w_status_ld  = 1'b1;
            w_status_nxt = c_STATUS_TIMEOUT;
            w_abort      = 1'b1;
          end
        end
        ST_DONE_HOLD: begin
          if (!pio_start) begin
            w_next_state = ST_IDLE;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_start_q  <= 1'b0;
      r_wdog     <= '0;
      r_opcode   <= '0;
      r_scale    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_cp_start <= 1'b0;
      r_cp_abort <= 1'b0;
      r_pio_done <= 1'b0;
      r_busy     <= 1'b0;
      r_status   <= c_STATUS_OK;
    end else begin
      r_state    <= w_next_state;
      r_start_q  <= pio_start;
      r_cp_start <= w_issue;
      r_cp_abort <= w_abort;
      r_busy     <= (w_next_state != ST_IDLE);
      r_pio_done <= (w_next_state == ST_DONE_HOLD);
      if (w_status_ld) begin
        r_status <= w_status_nxt;
      end
      if (w_wd_clr) begin
        r_wdog <= '0;
      end else if (w_wd_inc) begin
        r_wdog <= r_wdog + c_WD_ONE;
      end
      if (w_latch) begin
        r_opcode <= pio_instruct[c_OPC_LSB +: c_OPC_W];
        r_scale  <= pio_instruct[c_SCALE_LSB +: c_SCALE_W];
        r_x      <= pio_janela_pos[c_LO_LSB +: c_FIELD_W];
        r_y      <= pio_janela_pos[c_HI_LSB +: c_FIELD_W];
        r_w      <= pio_janela_dim[c_LO_LSB +: c_FIELD_W];
        r_h      <= pio_janela_dim[c_HI_LSB +: c_FIELD_W];
      end
    end
  end

  assign pio_done  = r_pio_done;
  assign status    = r_status;
  assign cp_start  = r_cp_start;
  assign cp_abort  = r_cp_abort;
  assign cp_opcode = r_opcode;
  assign cp_scale  = r_scale;
  assign cp_x      = r_x;
  assign cp_y      = r_y;
  assign cp_w      = r_w;
  assign cp_h      = r_h;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/coproc_cmd_sequencer.md
# coproc_cmd_sequencer

Sequences the image coprocessor datapath from the HPS PIO register set. Captures the instruction word, window position and window dimensions when software raises `pio_start`, then validates the command and issues it to the coprocessor with a start/done handshake. Returns completion to software on `pio_done` using a four-phase handshake, with a status code and a watchdog timeout. Sits in the FPGA top level between the `soc_system` PIO exports and the coprocessor core.

## Interface
- `IMG_W`, 320: image width in pixels; window bound for X.
- `IMG_H`, 240: image height in pixels; window bound for Y.
- `TIMEOUT_CYC`, 2**20: WAIT-state watchdog limit in clock cycles (≥ 2).
- `clk`  in  1  system clock; the PIO clock domain, so no synchronisers.
- `reset`  in  1  asynchronous, active-high reset.
- `pio_reset`  in  1  software soft reset, level, synchronous to `clk`.
- `pio_start`  in  1  software start, level; rising edge launches a command.
- `pio_instruct`  in  32  [3:0] opcode, [5:4] scale factor, [31:6] ignored.
- `pio_janela_pos`  in  32  [15:0] X, [31:16] Y.
- `pio_janela_dim`  in  32  [15:0] W, [31:16] H.
- `pio_done`  out  1  command finished; held until `pio_start` is low.
- `status`  out  3  result code; valid while `pio_done`=1.
- `cp_start`  out  1  one-cycle launch pulse to the coprocessor.
- `cp_abort`  out  1  one-cycle abort pulse to the coprocessor.
- `cp_opcode`  out  4  latched opcode.
- `cp_scale`  out  2  latched scale factor.
- `cp_x`, `cp_y`, `cp_w`, `cp_h`  out  16 each  latched window fields.
- `cp_done`  in  1  coprocessor completion pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Opcodes: 0 NOP, 1 COPY, 2 ZOOM_IN, 3 ZOOM_OUT, 4 WINDOW. Codes 5–15 are illegal.
- Status codes: 0 OK, 1 ILLEGAL_OP, 2 BAD_WINDOW, 3 TIMEOUT.
- `start_q` is the registered copy of `pio_start`. An edge is `pio_start & ~start_q`.
- State machine states: IDLE, CHECK, ISSUE, WAIT, DONE_HOLD.
- IDLE:
  - On an edge, latch all fields into the `cp_*` registers.
  - Clear the watchdog counter.
  - Go to CHECK.
- CHECK:
  - Illegal opcode → DONE_HOLD, status 1.
  - WINDOW command fails the bounds check → DONE_HOLD, status 2.
  - NOP → DONE_HOLD, status 0; no `cp_start` is issued.
  - Otherwise → ISSUE.
- Bounds check (WINDOW only):
  - Fails if W=0 or H=0.
  - Fails if X+W > IMG_W or Y+H > IMG_H.
  - Sums are computed at 17 bits, so 16-bit overflow counts as out of bounds.
- ISSUE: drive `cp_start`=1 for this cycle only, then go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - `cp_done`=1 → DONE_HOLD, status 0.
  - Counter reaches TIMEOUT_CYC−1 without `cp_done` → pulse `cp_abort`, go to DONE_HOLD, status 3.
  - If both occur in the same cycle, `cp_done` wins.
- DONE_HOLD: `pio_done`=1. When `pio_start`=0, go to IDLE; `pio_done` falls on that transition.
- `cp_done` is ignored outside WAIT.
- `pio_reset`=1 in any state:
  - Next state is IDLE; `status` clears to 0.
  - If the state was ISSUE or WAIT, pulse `cp_abort` for one cycle.
  - `start_q` keeps tracking `pio_start`, so a `pio_start` held high through the reset does not relaunch.
- Latched `cp_*` fields are stable from CHECK until the next accepted edge.

## Timing
- Values under `reset`: state IDLE; all outputs 0, including every `cp_*` field, `status`, `pio_done` and `busy`.
- Edge sampled at cycle N. CHECK is at N+1, ISSUE (`cp_start`=1) at N+2, WAIT from N+3.
- `cp_done` at cycle M gives `pio_done`=1 from M+1.
- NOP or rejected command: `pio_done`=1 from N+2.
- Timeout: `cp_abort` and the entry to DONE_HOLD coincide, at N+3+TIMEOUT_CYC−1.
- `pio_start` falling at cycle K gives `pio_done`=0 from K+1.
- A new edge is accepted no earlier than the cycle after re-entry to IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- `coproc_pkg` holds:
  - the opcode enum and the state enum;
  - the status codes;
  - the instruct/pos/dim bit-field positions;
  - default `IMG_W`/`IMG_H`.
- Sub-module `window_bounds_check`: combinational 17-bit bounds compare on the latched fields, reused by the coprocessor core.

## Test plan
- COPY with X=0,Y=0,W=320,H=240; `cp_done` 10 cycles after `cp_start` → `cp_start` at N+2, `pio_done`=1, status 0; `pio_done`=0 one cycle after `pio_start` drops.
- WINDOW with X=300,W=21 → no `cp_start`; status 2 at N+2. Repeat with W=0, and with X=0xFFFF,W=2 (overflow) → status 2 both times.
- Opcode 7 → status 1, no `cp_start`. NOP → status 0, no `cp_start`, `pio_done` at N+2.
- TIMEOUT_CYC=16 and `cp_done` never asserted → `cp_abort` pulses once, status 3, `pio_done`=1.
- `pio_reset` raised in WAIT with `pio_start` held high:
  - state returns to IDLE, `cp_abort` pulses once, status 0;
  - no relaunch until `pio_start` goes low then high again.
- `cp_done` and the watchdog limit in the same cycle → status 0, no `cp_abort`. A `cp_done` pulse in IDLE is ignored.
